// File: rtl/sweep_ctrl.sv
// Sweep sequencer for an 8-bit up/down counter: load lo, ramp to hi and back, repeat N passes.
// Optional macro SWEEP_PAUSE_EN adds a pause input that freezes the sweep mid-ramp.
module sweep_ctrl #(
  parameter int WIDTH  = 8,
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
`ifdef SWEEP_PAUSE_EN
  input  logic              pause,
`endif
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic [PASS_W-1:0] passes,
  input  logic [WIDTH-1:0]  ctr_count,
  output logic              ctr_up_down,
  output logic              ctr_load,
  output logic [WIDTH-1:0]  ctr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_UP   = 3'd2,
    S_DOWN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0]  ONE      = WIDTH'(1);
  localparam logic [WIDTH:0]    ONE_X    = (WIDTH+1)'(1);
  localparam logic [PASS_W-1:0] PASS_ONE = PASS_W'(1);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [PASS_W-1:0]   passes_q, passes_d;
  logic [PASS_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                cfg_ok;
  logic                paused;

  // Extended-width compare so lo=255 cannot wrap into a false "valid".
  assign cfg_ok = ({1'b0, hi} > ({1'b0, lo} + ONE_X)) && (passes != '0);

`ifdef SWEEP_PAUSE_EN
  assign paused = pause && ((state_q == S_UP) || (state_q == S_DOWN));
`else
  assign paused = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      lo_q       <= '0;
      hi_q       <= '0;
      passes_q   <= '0;
      pass_cnt_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      passes_q   <= passes_d;
      pass_cnt_q <= pass_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    passes_d   = passes_q;
    pass_cnt_d = pass_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start && cfg_ok) begin
          lo_d       = lo;
          hi_d       = hi;
          passes_d   = passes;
          pass_cnt_d = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: state_d = abort ? S_IDLE : S_UP;
      // Turn one count early: the counter steps onto the bound on the same edge.
      S_UP: begin
        if (abort)
          state_d = S_IDLE;
        else if (!paused && (ctr_count == hi_q - ONE))
          state_d = S_DOWN;
      end
      S_DOWN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (!paused && (ctr_count == lo_q + ONE)) begin
          if (pass_cnt_q == passes_q - PASS_ONE) begin
            state_d = S_DONE;
          end else begin
            pass_cnt_d = pass_cnt_q + PASS_ONE;
            state_d    = S_UP;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE);
    err_d  = (state_q == S_IDLE) && start && !cfg_ok;
  end

  always_comb begin
    ctr_data    = lo_q;
    ctr_load    = 1'b1;
    ctr_up_down = 1'b0;
    busy        = 1'b0;
    case (state_q)
      S_LOAD: busy = 1'b1;
      S_UP: begin
        ctr_load    = 1'b0;
        ctr_up_down = 1'b1;
        busy        = 1'b1;
      end
      S_DOWN: begin
        ctr_load = 1'b0;
        busy     = 1'b1;
      end
      default: ;
    endcase
    // The counter has no enable, so holding it means reloading its own value.
    if (paused) begin
      ctr_load = 1'b1;
      ctr_data = ctr_count;
    end
  end

  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Self-checking bench for sweep_ctrl with a behavioural counter and a queue-based
// reference of the expected count trace per sweep.
module tb_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
`ifdef SWEEP_PAUSE_EN
  logic       pause = 1'b0;
`endif
  logic [7:0] lo = 8'd0;
  logic [7:0] hi = 8'd0;
  logic [3:0] passes = 4'd0;
  logic [7:0] ctr_count = 8'hAA;
  logic       ctr_up_down, ctr_load, busy, done, err;
  logic [7:0] ctr_data;

  int tests = 0;
  int fails = 0;
  int busy_seen = 0;

  always #5 clk = ~clk;

  sweep_ctrl #(.WIDTH(8), .PASS_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
`ifdef SWEEP_PAUSE_EN
    .pause(pause),
`endif
    .lo(lo), .hi(hi), .passes(passes), .ctr_count(ctr_count),
    .ctr_up_down(ctr_up_down), .ctr_load(ctr_load), .ctr_data(ctr_data),
    .busy(busy), .done(done), .err(err)
  );

  // The controlled counter: load has priority, otherwise it always counts.
  always_ff @(posedge clk) begin
    if (ctr_load)         ctr_count <= ctr_data;
    else if (ctr_up_down) ctr_count <= ctr_count + 8'd1;
    else                  ctr_count <= ctr_count - 8'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (busy) busy_seen++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one sweep; abort_at/reset_at/pause_at trigger when the upward count hits that value (-1 = off).
  task automatic run_sweep(input logic [7:0] l, input logic [7:0] h, input logic [3:0] p,
                           input int abort_at, input int reset_at, input int pause_at,
                           input bit mid_start);
    int exp_q[$];
    bit dir_q[$];
    int extra;
    bit stopped;
    extra   = 0;
    stopped = 0;
    for (int k = 0; k < p; k++) begin
      for (int v = l; v < h; v++) begin exp_q.push_back(v); dir_q.push_back(1'b1); end
      for (int v = h; v > l; v--) begin exp_q.push_back(v); dir_q.push_back(1'b0); end
    end
    lo = l; hi = h; passes = p; start = 1'b1;
    busy_seen = 0;
    tick();
    start = 1'b0;
    check("load_busy", busy, 1);
    check("load_ctrl", ctr_load, 1);
    check("load_data", ctr_data, l);
    tick();
    for (int i = 0; i < exp_q.size() && !stopped; i++) begin
      check("cnt", ctr_count, exp_q[i]);
      check("busy", busy, 1);
      check("dir", ctr_up_down, dir_q[i]);
      check("nodone", done, 0);
      if (mid_start && i == 1) begin
        lo = 8'd0; hi = 8'd0; start = 1'b1;
        tick();
        start = 1'b0; lo = l; hi = h;
        check("mid_start_err", err, 0);
        check("mid_start_data", ctr_data, l);
        continue;
      end
      if (dir_q[i] && exp_q[i] == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_load", ctr_load, 1);
        tick();
        check("abort_cnt", ctr_count, l);
        check("abort_done2", done, 0);
        stopped = 1;
      end else if (dir_q[i] && exp_q[i] == reset_at) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_load", ctr_load, 1);
        check("rst_data", ctr_data, 0);
        check("rst_done", done, 0);
        check("rst_dir", ctr_up_down, 0);
        tick();
        check("rst_cnt", ctr_count, 0);
        stopped = 1;
      end else begin
`ifdef SWEEP_PAUSE_EN
        if (dir_q[i] && exp_q[i] == pause_at) begin
          pause = 1'b1;
          for (int j = 0; j < 5; j++) begin
            tick();
            check("pause_cnt", ctr_count, exp_q[i]);
            check("pause_busy", busy, 1);
          end
          pause = 1'b0;
          extra = 5;
        end
`endif
        tick();
      end
    end
    if (!stopped) begin
      check("done_pulse", done, 1);
      check("done_busy", busy, 0);
      check("done_cnt", ctr_count, l);
      check("busy_len", busy_seen, 1 + p * 2 * (h - l) + extra);
      tick();
      check("done_clear", done, 0);
      check("park_cnt", ctr_count, l);
    end
    if (pause_at < 0) check("pause_unused", extra, 0);
  endtask

  task automatic reject(input logic [7:0] l, input logic [7:0] h, input logic [3:0] p,
                        input logic [7:0] parked);
    lo = l; hi = h; passes = p; start = 1'b1;
    tick();
    start = 1'b0;
    check("rej_err", err, 1);
    check("rej_busy", busy, 0);
    check("rej_data", ctr_data, parked);
    tick();
    check("rej_err_clear", err, 0);
    check("rej_cnt", ctr_count, parked);
    check("rej_busy2", busy, 0);
  endtask

  initial begin
    logic [7:0] rl, rh;
    logic [3:0] rp;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    check("rst_load", ctr_load, 1);
    check("rst_data", ctr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_hold", ctr_count, 0);
    end

    run_sweep(8'h14, 8'h18, 4'd1, -1, -1, -1, 1'b1);
    run_sweep(8'h00, 8'h03, 4'd3, -1, -1, -1, 1'b0);
    reject(8'h20, 8'h21, 4'd2, 8'h00);
    reject(8'h20, 8'h30, 4'd0, 8'h00);
    reject(8'h40, 8'h10, 4'd1, 8'h00);
    reject(8'hFF, 8'hFF, 4'd1, 8'h00);
    run_sweep(8'd16, 8'd32, 4'd2, 20, -1, -1, 1'b0);
    run_sweep(8'd16, 8'd32, 4'd2, -1, 25, -1, 1'b0);
    run_sweep(8'd240, 8'd255, 4'd2, -1, -1, -1, 1'b0);
    reject(8'h05, 8'h06, 4'd3, 8'd240);
`ifdef SWEEP_PAUSE_EN
    run_sweep(8'd14, 8'd20, 4'd1, -1, -1, 17, 1'b0);
`endif
    for (int n = 0; n < 8; n++) begin
      rl = 8'($urandom_range(0, 200));
      rh = rl + 8'($urandom_range(2, 20));
      rp = 4'($urandom_range(1, 4));
      run_sweep(rl, rh, rp, -1, -1, -1, 1'b0);
      reject(rl, rl + 8'd1, rp, rl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
